// File: rtl/sv32_pkg.sv
// Sv32 constants, PTE field helpers, walker state encodings and the ITLB entry layout.
package sv32_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned VPN_W      = 10;
    localparam int unsigned PPN_W      = 20;
    localparam int unsigned SATP_PPN_W = 22;
    localparam int unsigned ASID_W     = 9;
    localparam int unsigned PRIV_W     = 2;
    localparam int unsigned STATE_W    = 3;

    localparam int unsigned PTE_V = 0;
    localparam int unsigned PTE_R = 1;
    localparam int unsigned PTE_W = 2;
    localparam int unsigned PTE_X = 3;
    localparam int unsigned PTE_U = 4;
    localparam int unsigned PTE_G = 5;
    localparam int unsigned PTE_A = 6;
    localparam int unsigned PTE_D = 7;

    localparam logic [PRIV_W-1:0] PRIV_U = 2'b00;
    localparam logic [PRIV_W-1:0] PRIV_S = 2'b01;

    typedef logic [STATE_W-1:0] walk_state_t;
    localparam walk_state_t ST_IDLE  = 3'd0;
    localparam walk_state_t ST_L1    = 3'd1;
    localparam walk_state_t ST_L0    = 3'd2;
    localparam walk_state_t ST_RESP  = 3'd3;
    localparam walk_state_t ST_DRAIN = 3'd4;

    typedef struct packed {
        logic [VPN_W-1:0]  vpn1;
        logic [VPN_W-1:0]  vpn0;
        logic [PPN_W-1:0]  ppn;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic              u;
        logic              superpage;
        logic              valid;
    } tlb_entry_t;

    function automatic logic [VPN_W-1:0] get_vpn1(input logic [XLEN-1:0] va);
        return va[31:22];
    endfunction

    function automatic logic [VPN_W-1:0] get_vpn0(input logic [XLEN-1:0] va);
        return va[21:12];
    endfunction

    // PPN bits above [19:0] do not fit a 32-bit physical address and are dropped
    function automatic logic [PPN_W-1:0] pte_ppn(input logic [XLEN-1:0] pte);
        return pte[29:10];
    endfunction

    function automatic logic [VPN_W-1:0] pte_ppn1(input logic [XLEN-1:0] pte);
        return pte[29:20];
    endfunction

    function automatic logic [VPN_W-1:0] pte_ppn0(input logic [XLEN-1:0] pte);
        return pte[19:10];
    endfunction

endpackage

// File: rtl/itlb_ptw_if.sv
// IFU translation request/response and PTE memory read signals.
interface itlb_ptw_if;
    import sv32_pkg::*;

    logic                  req_valid_i;
    logic [XLEN-1:0]       req_vaddr_i;
    logic                  enable_i;
    logic [PRIV_W-1:0]     priv_i;
    logic [SATP_PPN_W-1:0] satp_ppn_i;
    logic [ASID_W-1:0]     satp_asid_i;
    logic                  flush_i;
    logic                  mem_req_o;
    logic [XLEN-1:0]       mem_addr_o;
    logic [XLEN-1:0]       mem_rdata_i;
    logic                  mem_rvalid_i;
    logic                  resp_valid_o;
    logic [XLEN-1:0]       resp_paddr_o;
    logic                  resp_page_fault_o;

    modport slave (
        input  req_valid_i, req_vaddr_i, enable_i, priv_i, satp_ppn_i, satp_asid_i,
               flush_i, mem_rdata_i, mem_rvalid_i,
        output mem_req_o, mem_addr_o, resp_valid_o, resp_paddr_o, resp_page_fault_o
    );

    modport master (
        output req_valid_i, req_vaddr_i, enable_i, priv_i, satp_ppn_i, satp_asid_i,
               flush_i, mem_rdata_i, mem_rvalid_i,
        input  mem_req_o, mem_addr_o, resp_valid_o, resp_paddr_o, resp_page_fault_o
    );

endinterface

// File: rtl/itlb_cam.sv
// Fully associative ASID-tagged ITLB: parallel lookup, round-robin fill, flash flush.
module itlb_cam
    import sv32_pkg::*;
#(
    parameter int unsigned TLB_ENTRIES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   lookup_vaddr,
    input  logic [ASID_W-1:0] lookup_asid,
    output logic              hit_c,
    output logic              u_c,
    output logic [XLEN-1:0]   paddr_c,
    input  logic              fill_en,
    input  tlb_entry_t        fill_entry,
    input  logic              flush
);

    localparam int unsigned IDX_W = $clog2(TLB_ENTRIES);

    tlb_entry_t       entries [TLB_ENTRIES];
    logic [IDX_W-1:0] rr_ptr;

    // Descending scan so the lowest matching index wins
    always_comb begin
        hit_c   = 1'b0;
        u_c     = 1'b0;
        paddr_c = '0;
        for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
            if (entries[i].valid
                && entries[i].vpn1 == get_vpn1(lookup_vaddr)
                && (entries[i].superpage || entries[i].vpn0 == get_vpn0(lookup_vaddr))
                && (entries[i].g || entries[i].asid == lookup_asid)) begin
                hit_c   = 1'b1;
                u_c     = entries[i].u;
                paddr_c = entries[i].superpage
                        ? {entries[i].ppn[PPN_W-1:VPN_W], lookup_vaddr[21:0]}
                        : {entries[i].ppn, lookup_vaddr[11:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TLB_ENTRIES; i++) entries[i] <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < TLB_ENTRIES; i++) entries[i].valid <= 1'b0;
        end else if (fill_en) begin
            entries[rr_ptr] <= fill_entry;
            rr_ptr          <= rr_ptr + IDX_W'(1);
        end
    end

endmodule

// File: rtl/itlb_ptw.sv
// Instruction-side Sv32 translation: ITLB lookup, two-level page walk, fault checks.
module itlb_ptw
    import sv32_pkg::*;
#(
    parameter int unsigned TLB_ENTRIES = 4
) (
    input logic       clk,
    input logic       rst_n,
    itlb_ptw_if.slave bus
);

    walk_state_t       state, state_d;
    logic              mem_req, mem_req_d;
    logic [XLEN-1:0]   mem_addr, mem_addr_d;
    logic              resp_valid, resp_valid_d;
    logic [XLEN-1:0]   resp_paddr, resp_paddr_d;
    logic              resp_fault, resp_fault_d;
    logic [XLEN-1:0]   vaddr_q, vaddr_d;
    logic [PRIV_W-1:0] priv_q, priv_d;
    logic [ASID_W-1:0] asid_q, asid_d;

    logic              hit_c, hit_u_c;
    logic [XLEN-1:0]   hit_paddr_c;
    logic              fill_en_c;
    tlb_entry_t        fill_entry_c;

    logic [XLEN-1:0]   pte_c, leaf_paddr_c;
    logic              super_c, pte_invalid_c, pte_leaf_c, leaf_ok_c;
    logic              unused_bits;

    itlb_cam #(.TLB_ENTRIES(TLB_ENTRIES)) u_cam (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_vaddr (bus.req_vaddr_i),
        .lookup_asid  (bus.satp_asid_i),
        .hit_c        (hit_c),
        .u_c          (hit_u_c),
        .paddr_c      (hit_paddr_c),
        .fill_en      (fill_en_c),
        .fill_entry   (fill_entry_c),
        .flush        (bus.flush_i)
    );

    // PTE decode; a leaf seen in L1 is a superpage
    assign pte_c         = bus.mem_rdata_i;
    assign super_c       = (state == ST_L1);
    assign pte_invalid_c = !pte_c[PTE_V] || (!pte_c[PTE_R] && pte_c[PTE_W]);
    assign pte_leaf_c    = pte_c[PTE_R] || pte_c[PTE_X];
    assign leaf_ok_c     = pte_c[PTE_X] && pte_c[PTE_A]
                         && (pte_c[PTE_U] == (priv_q == PRIV_U))
                         && (!super_c || pte_ppn0(pte_c) == '0);
    assign leaf_paddr_c  = super_c ? {pte_ppn1(pte_c), vaddr_q[21:0]}
                                   : {pte_ppn(pte_c), vaddr_q[11:0]};
    assign fill_entry_c  = '{vpn1: get_vpn1(vaddr_q), vpn0: get_vpn0(vaddr_q),
                             ppn: pte_ppn(pte_c), asid: asid_q, g: pte_c[PTE_G],
                             u: pte_c[PTE_U], superpage: super_c, valid: 1'b1};
    assign unused_bits   = ^{pte_c[31:30], pte_c[9:PTE_D], bus.satp_ppn_i[21:20]};

    always_comb begin
        state_d      = state;
        mem_req_d    = mem_req;
        mem_addr_d   = mem_addr;
        resp_valid_d = 1'b0;
        resp_paddr_d = resp_paddr;
        resp_fault_d = resp_fault;
        vaddr_d      = vaddr_q;
        priv_d       = priv_q;
        asid_d       = asid_q;
        fill_en_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    vaddr_d = bus.req_vaddr_i;
                    priv_d  = bus.priv_i;
                    asid_d  = bus.satp_asid_i;
                    if (!bus.enable_i) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_paddr_d = bus.req_vaddr_i;
                        resp_fault_d = 1'b0;
                    end else if (hit_c && !bus.flush_i) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_paddr_d = hit_paddr_c;
                        resp_fault_d = (hit_u_c != (bus.priv_i == PRIV_U));
                    end else begin
                        state_d    = ST_L1;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {bus.satp_ppn_i[PPN_W-1:0], 12'h000}
                                   + XLEN'({get_vpn1(bus.req_vaddr_i), 2'b00});
                    end
                end
            end
            ST_L1, ST_L0: begin
                if (bus.flush_i) begin
                    // Walk result is stale: absorb the read, then retranslate
                    if (bus.mem_rvalid_i) begin
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (bus.mem_rvalid_i) begin
                    mem_req_d    = 1'b0;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_paddr_d = '0;
                    resp_fault_d = 1'b1;
                    if (!pte_invalid_c && pte_leaf_c && leaf_ok_c) begin
                        resp_paddr_d = leaf_paddr_c;
                        resp_fault_d = 1'b0;
                        fill_en_c    = 1'b1;
                    end else if (!pte_invalid_c && !pte_leaf_c && super_c) begin
                        state_d      = ST_L0;
                        mem_req_d    = 1'b1;
                        mem_addr_d   = {pte_ppn(pte_c), 12'h000}
                                     + XLEN'({get_vpn0(vaddr_q), 2'b00});
                        resp_valid_d = 1'b0;
                        resp_fault_d = 1'b0;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_DRAIN: begin
                if (bus.mem_rvalid_i) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_paddr <= '0;
            resp_fault <= 1'b0;
            vaddr_q    <= '0;
            priv_q     <= '0;
            asid_q     <= '0;
        end else begin
            state      <= state_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
            resp_valid <= resp_valid_d;
            resp_paddr <= resp_paddr_d;
            resp_fault <= resp_fault_d;
            vaddr_q    <= vaddr_d;
            priv_q     <= priv_d;
            asid_q     <= asid_d;
        end
    end

    assign bus.mem_req_o         = mem_req;
    assign bus.mem_addr_o        = mem_addr;
    assign bus.resp_valid_o      = resp_valid;
    assign bus.resp_paddr_o      = resp_paddr;
    assign bus.resp_page_fault_o = resp_fault;

endmodule

// File: tb/tb_itlb_ptw.sv
// Directed bench for itlb_ptw: bypass, walks, faults, flush and reset mid-walk.
module tb_itlb_ptw;
    import sv32_pkg::*;

    logic clk;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    itlb_ptw_if bus ();

    itlb_ptw #(.TLB_ENTRIES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic req_start(input logic [31:0] va);
        bus.req_vaddr_i = va;
        bus.req_valid_i = 1'b1;
        tick();
    endtask

    task automatic mem_give(input logic [31:0] d);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = d;
        tick();
        bus.mem_rvalid_i = 1'b0;
    endtask

    task automatic resp_done();
        bus.req_valid_i = 1'b0;
        tick();
    endtask

    // Miss that resolves at level 1 (superpage leaf or fault)
    task automatic walk_l1(input string tag, input logic [31:0] va, input logic [31:0] l1a,
                           input logic [31:0] pte, input logic flt, input logic [31:0] pa);
        req_start(va);
        chk({tag, ".mem_req"}, 32'(bus.mem_req_o), 32'd1);
        chk({tag, ".l1_addr"}, bus.mem_addr_o, l1a);
        mem_give(pte);
        chk({tag, ".resp_valid"}, 32'(bus.resp_valid_o), 32'd1);
        chk({tag, ".fault"}, 32'(bus.resp_page_fault_o), 32'(flt));
        if (!flt) chk({tag, ".paddr"}, bus.resp_paddr_o, pa);
        resp_done();
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.req_valid_i  = 1'b0;
        bus.req_vaddr_i  = '0;
        bus.enable_i     = 1'b0;
        bus.priv_i       = PRIV_S;
        bus.satp_ppn_i   = 22'h080000;
        bus.satp_asid_i  = 9'd5;
        bus.flush_i      = 1'b0;
        bus.mem_rdata_i  = '0;
        bus.mem_rvalid_i = 1'b0;
        tick();
        tick();
        chk("reset.resp_valid", 32'(bus.resp_valid_o), 32'd0);
        chk("reset.mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("reset.mem_addr", bus.mem_addr_o, 32'd0);
        chk("reset.paddr", bus.resp_paddr_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // Bypass
        req_start(32'h3000_0000);
        chk("bypass.resp_valid", 32'(bus.resp_valid_o), 32'd1);
        chk("bypass.paddr", bus.resp_paddr_o, 32'h3000_0000);
        chk("bypass.fault", 32'(bus.resp_page_fault_o), 32'd0);
        chk("bypass.mem_req", 32'(bus.mem_req_o), 32'd0);
        resp_done();
        chk("bypass.pulse", 32'(bus.resp_valid_o), 32'd0);
        bus.enable_i = 1'b1;

        // 4 KiB two-level walk
        req_start(32'h4000_1234);
        chk("walk4k.mem_req_l1", 32'(bus.mem_req_o), 32'd1);
        chk("walk4k.l1_addr", bus.mem_addr_o, 32'h8000_0400);
        chk("walk4k.no_resp_l1", 32'(bus.resp_valid_o), 32'd0);
        mem_give(32'h2000_0401);
        chk("walk4k.mem_req_l0", 32'(bus.mem_req_o), 32'd1);
        chk("walk4k.l0_addr", bus.mem_addr_o, 32'h8000_1004);
        mem_give(32'h2004_8C4B);
        chk("walk4k.resp_valid", 32'(bus.resp_valid_o), 32'd1);
        chk("walk4k.paddr", bus.resp_paddr_o, 32'h8012_3234);
        chk("walk4k.fault", 32'(bus.resp_page_fault_o), 32'd0);
        chk("walk4k.mem_idle", 32'(bus.mem_req_o), 32'd0);
        resp_done();

        // Hit on the cached 4 KiB page
        req_start(32'h4000_1238);
        chk("hit.resp_valid", 32'(bus.resp_valid_o), 32'd1);
        chk("hit.paddr", bus.resp_paddr_o, 32'h8012_3238);
        chk("hit.mem_req", 32'(bus.mem_req_o), 32'd0);
        resp_done();

        // Superpage, then a misaligned superpage
        walk_l1("super", 32'h8040_0010, 32'h8000_0804, 32'h2010_004B, 1'b0, 32'h8040_0010);
        walk_l1("super_misalign", 32'hC000_0000, 32'h8000_0C00, 32'h2010_044B, 1'b1, 32'h0);

        // Permission faults; every re-request must walk again
        walk_l1("perm_x0", 32'h0080_0000, 32'h8000_0008, 32'h2000_0043, 1'b1, 32'h0);
        bus.priv_i = PRIV_U;
        walk_l1("perm_u", 32'h0080_0000, 32'h8000_0008, 32'h2000_004B, 1'b1, 32'h0);
        bus.priv_i = PRIV_S;
        walk_l1("perm_a0", 32'h0080_0000, 32'h8000_0008, 32'h2000_000B, 1'b1, 32'h0);

        // A non-global entry must miss under a different ASID
        bus.satp_asid_i = 9'd6;
        walk_l1("asid_miss", 32'h4000_1234, 32'h8000_0400, 32'h0000_0000, 1'b1, 32'h0);
        bus.satp_asid_i = 9'd5;

        // Flush in L0 with the read delayed three cycles
        req_start(32'h4000_5000);
        mem_give(32'h2000_0401);
        chk("flush.l0_addr", bus.mem_addr_o, 32'h8000_1014);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        chk("flush.drain_req", 32'(bus.mem_req_o), 32'd1);
        chk("flush.no_resp0", 32'(bus.resp_valid_o), 32'd0);
        tick();
        chk("flush.no_resp1", 32'(bus.resp_valid_o), 32'd0);
        tick();
        chk("flush.no_resp2", 32'(bus.resp_valid_o), 32'd0);
        mem_give(32'h2004_8C4B);
        chk("flush.drained_req", 32'(bus.mem_req_o), 32'd0);
        chk("flush.no_resp3", 32'(bus.resp_valid_o), 32'd0);
        tick();
        chk("flush.rewalk_req", 32'(bus.mem_req_o), 32'd1);
        chk("flush.rewalk_addr", bus.mem_addr_o, 32'h8000_0400);
        mem_give(32'h2000_0401);
        chk("flush.rewalk_l0", bus.mem_addr_o, 32'h8000_1014);
        mem_give(32'h2004_8C4B);
        chk("flush.rewalk_valid", 32'(bus.resp_valid_o), 32'd1);
        chk("flush.rewalk_paddr", bus.resp_paddr_o, 32'h8012_3000);
        resp_done();
        walk_l1("flush.old_miss", 32'h4000_1238, 32'h8000_0400, 32'h0000_0000, 1'b1, 32'h0);

        // Reset while L1 is outstanding
        req_start(32'h8040_0010);
        chk("rst.in_l1", 32'(bus.mem_req_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst.mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst.mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst.resp_valid", 32'(bus.resp_valid_o), 32'd0);
        bus.req_valid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_give(32'h2010_004B);
        chk("rst.late_rvalid_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst.late_rvalid_resp", 32'(bus.resp_valid_o), 32'd0);
        tick();
        chk("rst.idle_resp", 32'(bus.resp_valid_o), 32'd0);
        walk_l1("rst.tlb_empty", 32'h4000_5000, 32'h8000_0400, 32'h0000_0000, 1'b1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
